// File: rtl/datapath_multiciclo.sv
// Multi-cycle MIPS-subset datapath: R-type (add/sub/and/or/nor/slt), addi, lw, sw.
// One instruction per valid/ready handshake, sequenced IDLE -> DECODE -> EXEC -> {MEM} -> {WB}.
module datapath_multiciclo #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              Zflag,
    output logic              illegal_op,
    output logic              misaligned,
    input  logic [4:0]        dbg_reg_addr,
    output logic [DATA_W-1:0] dbg_reg_data
);

    localparam int MEM_AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_t;

    state_t              state_reg;
    logic [31:0]         ir_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic [DATA_W-1:0]   alu_out_reg;
    logic [DATA_W-1:0]   mdr_reg;
    logic [DATA_W-1:0]   result_reg;
    logic                zflag_reg;
    logic                done_reg;
    logic                illegal_reg;
    logic                misaligned_reg;

    logic [DATA_W-1:0]   regs [32];
    logic [DATA_W-1:0]   mem  [MEM_WORDS];

    // Instruction fields
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [DATA_W-1:0]   imm_ext;
    logic                is_rtype;
    logic                is_addi;
    logic                is_lw;
    logic                is_sw;
    logic                funct_ok;
    logic                instr_legal;

    assign opcode   = ir_reg[31:26];
    assign rs       = ir_reg[25:21];
    assign rt       = ir_reg[20:16];
    assign rd       = ir_reg[15:11];
    assign funct    = ir_reg[5:0];
    assign imm_ext  = {{(DATA_W-16){ir_reg[15]}}, ir_reg[15:0]};
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);

    alu_op_t             alu_op;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;

    // ALU control: non-R-type instructions always add (addi and address generation)
    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b0;
        if (is_rtype) begin
            funct_ok = 1'b1;
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                default: funct_ok = 1'b0;
            endcase
        end
    end

    assign instr_legal = (is_rtype && funct_ok) || is_addi || is_lw || is_sw;
    assign alu_b       = is_rtype ? b_reg : imm_ext;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = a_reg + alu_b;
            ALU_SUB: alu_result = a_reg - alu_b;
            ALU_AND: alu_result = a_reg & alu_b;
            ALU_OR:  alu_result = a_reg | alu_b;
            ALU_NOR: alu_result = ~(a_reg | alu_b);
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    // Word RAM with registered read; address bits above the word index wrap
    logic [MEM_AW-1:0]   ram_idx;
    logic                ram_we;

    assign ram_idx = alu_out_reg[MEM_AW+1:2];
    assign ram_we  = (state_reg == S_MEM) && is_sw && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= b_reg;
        end
        mdr_reg <= mem[ram_idx];
    end

    // Register bank; $0 is reset to zero and never written
    logic [4:0]          wb_addr;
    logic [DATA_W-1:0]   wb_data;

    assign wb_addr = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr_reg : alu_out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (state_reg == S_WB && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign dbg_reg_data = regs[dbg_reg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ir_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            alu_out_reg    <= '0;
            result_reg     <= '0;
            zflag_reg      <= 1'b0;
            done_reg       <= 1'b0;
            illegal_reg    <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir_reg         <= instruction;
                        illegal_reg    <= 1'b0;
                        misaligned_reg <= 1'b0;
                        state_reg      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg <= regs[rs];
                    b_reg <= regs[rt];
                    if (!instr_legal) begin
                        illegal_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= S_IDLE;
                    end else begin
                        state_reg   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out_reg <= alu_result;
                    result_reg  <= alu_result;
                    zflag_reg   <= (alu_result == '0);
                    if (is_lw || is_sw) begin
                        if (alu_result[1:0] != 2'b00) begin
                            misaligned_reg <= 1'b1;
                            done_reg       <= 1'b1;
                            state_reg      <= S_IDLE;
                        end else begin
                            state_reg      <= S_MEM;
                        end
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (is_sw) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_WB: begin
                    if (is_lw) begin
                        result_reg <= mdr_reg;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_reg == S_IDLE);
    assign done        = done_reg;
    assign result      = result_reg;
    assign Zflag       = zflag_reg;
    assign illegal_op  = illegal_reg;
    assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Scoreboard bench for datapath_multiciclo: a driver issues instructions and queues the
// architecturally expected outcome; a monitor pops and compares on every done pulse.
module tb_datapath_multiciclo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic        done;
    logic [31:0] result;
    logic        Zflag;
    logic        illegal_op;
    logic        misaligned;
    logic [4:0]  dbg_reg_addr = '0;
    logic [31:0] dbg_reg_data;

    datapath_multiciclo #(.DATA_W(32), .MEM_WORDS(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .done         (done),
        .result       (result),
        .Zflag        (Zflag),
        .illegal_op   (illegal_op),
        .misaligned   (misaligned),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        logic        chk_res;
        logic        z;
        logic        ill;
        logic        mis;
        int          lat;
        int          hs;
        logic [4:0]  chk_reg;
        logic [31:0] chk_val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    logic        m_z;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_z = 1'b0;
    endtask

    // Architectural reference: what one instruction does to regs/memory/flags, and when.
    task automatic model_push(input logic [31:0] ins);
        exp_t        e;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, dest;
        logic [31:0] a, b, sx, r;
        logic        wr;
        op = ins[31:26]; fn = ins[5:0];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        sx = {{16{ins[15]}}, ins[15:0]};
        a = m_regs[rs]; b = m_regs[rt];
        e.ins = ins; e.ill = 1'b0; e.mis = 1'b0; e.chk_res = 1'b1;
        e.hs = cyc + 1; r = '0; wr = 1'b0; dest = rt;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                            fn == 6'h25 || fn == 6'h27 || fn == 6'h2A)) begin
            case (fn)
                6'h20:   r = a + b;
                6'h22:   r = a - b;
                6'h24:   r = a & b;
                6'h25:   r = a | b;
                6'h27:   r = ~(a | b);
                default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            dest = rd; wr = 1'b1; e.lat = 4; m_z = (r == 0); e.res = r;
        end else if (op == 6'h08) begin
            r = a + sx; wr = 1'b1; e.lat = 4; m_z = (r == 0); e.res = r;
        end else if (op == 6'h23 || op == 6'h2B) begin
            r = a + sx; m_z = (r == 0); e.res = r;
            if (r[1:0] != 2'b00) begin
                e.mis = 1'b1; e.lat = 3;
            end else if (op == 6'h23) begin
                e.res = m_mem[r[7:2]]; r = e.res; wr = 1'b1; e.lat = 5;
            end else begin
                m_mem[r[7:2]] = b; e.lat = 4;
            end
        end else begin
            e.ill = 1'b1; e.lat = 2; e.chk_res = 1'b0; e.res = '0;
        end
        if (wr && dest != 5'd0) m_regs[dest] = r;
        e.chk_reg = dest;
        e.chk_val = m_regs[dest];
        e.z = m_z;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; issues as soon as the DUT is ready (including on the done cycle).
    task automatic issue(input logic [31:0] ins);
        int w = 0;
        while (!instr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'(instr_ready), 32'd1);
            finish_now();
        end
        instr_valid = 1'b1;
        instruction = ins;
        model_push(ins);
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = $urandom;
        chk("flags_cleared", {30'd0, illegal_op, misaligned}, 32'd0);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        int          k, p;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn, op;
        logic [31:0] ins;
        k   = $urandom_range(0, 9);
        rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        imm = 16'($urandom);
        if (k <= 4) begin
            case ($urandom_range(0, 5))
                0:       fn = 6'h20;
                1:       fn = 6'h22;
                2:       fn = 6'h24;
                3:       fn = 6'h25;
                4:       fn = 6'h27;
                default: fn = 6'h2A;
            endcase
            ins = {6'h00, rs, rt, rd, 5'($urandom), fn};
        end else if (k == 5) begin
            ins = {6'h08, rs, rt, imm};
        end else if (k <= 8) begin
            op = (k == 8) ? 6'h2B : 6'h23;
            p  = $urandom_range(0, 99);
            if (p < 70) begin
                rs = 5'd0;
                imm[1:0] = 2'b00;
            end else if (p < 85) begin
                rs = 5'd0;
            end
            ins = {op, rs, rt, imm};
        end else if ($urandom_range(0, 1) == 1) begin
            fn = 6'($urandom);
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 ||
                fn == 6'h27 || fn == 6'h2A) fn = 6'h3F;
            ins = {6'h00, rs, rt, rd, 5'd0, fn};
        end else begin
            op = 6'($urandom);
            if (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B) op = 6'h3F;
            ins = {op, rs, rt, imm};
        end
        return ins;
    endfunction

    // Monitor: one line per retired instruction, compared against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn ins=%08h result=%08h Z=%0d ill=%0d mis=%0d lat=%0d",
                             e.ins, result, Zflag, illegal_op, misaligned, cyc - e.hs + 1);
                    chk("latency", 32'(cyc - e.hs + 1), 32'(e.lat));
                    if (e.chk_res) chk("result", result, e.res);
                    chk("zflag", 32'(Zflag), 32'(e.z));
                    chk("illegal_op", 32'(illegal_op), 32'(e.ill));
                    chk("misaligned", 32'(misaligned), 32'(e.mis));
                    dbg_reg_addr = e.chk_reg;
                    #1;
                    chk("reg_value", dbg_reg_data, e.chk_val);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zflag", 32'(Zflag), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            dbg_reg_addr = 5'(i);
            #1;
            chk("rst_reg", dbg_reg_data, m_regs[i]);
        end
        @(negedge clk);

        // Directed sequence: addi, sub to zero, sw/lw round trip, misaligned, $0 write, illegal
        issue(32'h20010005);
        issue(32'h20020005);
        issue(32'h00221822);
        issue(32'hAC010008);
        issue(32'h8C040008);
        issue(32'h8C050002);
        issue(32'h20000007);
        issue(32'hFC000000);
        issue(32'h20080001);
        drain();

        for (int r = 1; r < 32; r++) issue({6'h08, 5'd0, 5'(r), 16'($urandom)});
        for (int i = 0; i < 64; i++) issue({6'h2B, 5'd0, 5'($urandom), 16'(i * 4)});
        repeat (300) issue(gen_instr());
        drain();

        // Reset asserted while addi $6,$0,9 is in EXEC: it must never retire
        issue_abort();

        @(negedge clk);
        issue(32'h20070003);
        drain();
        finish_now();
    end

    task automatic issue_abort();
        instr_valid = 1'b1;
        instruction = 32'h20060009;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        dbg_reg_addr = 5'd6;
        #1;
        chk("abort_reg6", dbg_reg_data, m_regs[6]);
        chk("abort_result", result, 32'd0);
        chk("abort_zflag", 32'(Zflag), 32'd0);
    endtask

endmodule
